// File: rtl/spi_pkg.sv
// Shared SPI constants: default word width and bit-counter sizing, used by the
// slave shift register here and by the SPI master side.
package spi_pkg;

  localparam int SPI_WIDTH = 8;

  // A one-bit word still needs a one-bit counter, so never return zero.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

  localparam int SPI_CNT_W = cnt_width(SPI_WIDTH);

endpackage

// File: rtl/shift_register.sv
// SPI-slave shift register: receives MSB-first words while SS is high,
// publishes each finished word with a one-cycle SSPIF pulse and echoes it back.
module shift_register
  import spi_pkg::*;
#(
  parameter int WIDTH = SPI_WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SS,
  input  logic             Data_In,
  output logic             Data_Out,
  output logic [0:WIDTH-1] ByteOut,
  output logic             SSPIF
);

  localparam int               CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // Only the newest WIDTH-1 received bits can reach a completed word; the
  // oldest shift-register bit is always shifted out unread, so it is not kept.
  logic [1:WIDTH-1] sr;
  logic [0:WIDTH-1] tx;
  logic [0:WIDTH-1] next_word;
  logic [CNT_W-1:0] cnt;

  assign next_word = {sr, Data_In};

  always_ff @(posedge Clk) begin
    if (Rst) begin
      sr       <= '0;
      tx       <= '0;
      cnt      <= '0;
      ByteOut  <= '0;
      Data_Out <= 1'b0;
      SSPIF    <= 1'b0;
    end else if (SS) begin
      sr       <= next_word[1:WIDTH-1];
      Data_Out <= tx[cnt];
      if (cnt == LAST_BIT) begin
        ByteOut <= next_word;
        tx      <= next_word;
        SSPIF   <= 1'b1;
        cnt     <= '0;
      end else begin
        SSPIF <= 1'b0;
        cnt   <= cnt + 1'b1;
      end
    end else begin
      sr       <= '0;
      cnt      <= '0;
      Data_Out <= 1'b0;
      SSPIF    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shift_register.sv
// Self-checking bench for shift_register: a bit-level reference model pushes
// expected outputs per edge into a scoreboard that is popped on the next falling edge.
module tb_shift_register;
  import spi_pkg::*;

  localparam int W = 8;

  logic         Clk = 1'b0;
  logic         Rst = 1'b1;
  logic         SS = 1'b0;
  logic         Data_In = 1'b0;
  logic         Data_Out;
  logic [0:W-1] ByteOut;
  logic         SSPIF;

  int passCount = 0;
  int checkCount = 0;

  typedef struct {
    logic [7:0] byteOut;
    logic       flag;
    logic       dout;
  } expect_t;

  expect_t scoreboard[$];

  logic [7:0] modelWord = '0;
  logic [7:0] modelTx = '0;
  logic [7:0] modelByte = '0;
  logic       modelFlag = 1'b0;
  logic       modelDout = 1'b0;
  int         modelBits = 0;

  shift_register #(.WIDTH(W)) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SS       (SS),
    .Data_In  (Data_In),
    .Data_Out (Data_Out),
    .ByteOut  (ByteOut),
    .SSPIF    (SSPIF)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected)
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, observed, expected, $time);
    else
      passCount++;
  endtask

  // Reference behaviour for one rising edge, written as a bit-counting model.
  task automatic modelEdge(input logic r, input logic s, input logic d);
    expect_t e;
    if (r) begin
      modelWord = '0; modelTx = '0; modelByte = '0;
      modelFlag = 1'b0; modelDout = 1'b0; modelBits = 0;
    end else if (s) begin
      modelDout = modelTx[7 - modelBits];
      modelWord = {modelWord[6:0], d};
      modelBits++;
      if (modelBits == 8) begin
        modelByte = modelWord;
        modelTx   = modelWord;
        modelFlag = 1'b1;
        modelBits = 0;
      end else begin
        modelFlag = 1'b0;
      end
    end else begin
      modelWord = '0; modelBits = 0;
      modelFlag = 1'b0; modelDout = 1'b0;
    end
    e.byteOut = modelByte;
    e.flag    = modelFlag;
    e.dout    = modelDout;
    scoreboard.push_back(e);
  endtask

  // Called on a falling edge: drive, let one rising edge pass, then compare.
  task automatic applyStimulus(input logic r, input logic s, input logic d);
    expect_t e;
    Rst = r; SS = s; Data_In = d;
    modelEdge(r, s, d);
    @(negedge Clk);
    e = scoreboard.pop_front();
    checkOutput("sb_byteout", 32'(ByteOut), 32'(e.byteOut));
    checkOutput("sb_sspif", 32'(SSPIF), 32'(e.flag));
    checkOutput("sb_dataout", 32'(Data_Out), 32'(e.dout));
  endtask

  task automatic sendByte(input logic [7:0] b, output logic [7:0] echo);
    for (int i = 7; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b1, b[i]);
      echo[i] = Data_Out;
    end
  endtask

  logic [7:0] echo;

  initial begin
    @(negedge Clk);

    // Reset held with SS active and toggling data.
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("reset_byteout", 32'(ByteOut), 32'h00);
    checkOutput("reset_sspif", 32'(SSPIF), 32'h0);
    checkOutput("reset_dataout", 32'(Data_Out), 32'h0);

    // Single word 0x80, then one extra bit.
    sendByte(8'h80, echo);
    checkOutput("single_byteout", 32'(ByteOut), 32'h80);
    checkOutput("single_msb", 32'(ByteOut[0]), 32'h1);
    checkOutput("single_sspif", 32'(SSPIF), 32'h1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("ninth_sspif", 32'(SSPIF), 32'h0);
    checkOutput("ninth_byteout", 32'(ByteOut), 32'h80);
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Back-to-back words with echo of the previous word.
    sendByte(8'hA5, echo);
    checkOutput("b2b_first", 32'(ByteOut), 32'hA5);
    checkOutput("b2b_first_flag", 32'(SSPIF), 32'h1);
    checkOutput("echo_of_80", 32'(echo), 32'h80);
    sendByte(8'h3C, echo);
    checkOutput("b2b_second", 32'(ByteOut), 32'h3C);
    checkOutput("b2b_second_flag", 32'(SSPIF), 32'h1);
    checkOutput("echo_of_a5", 32'(echo), 32'hA5);

    // Abort after 5 bits, deselect for 2 edges, then a full 0xFF.
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("abort_byteout", 32'(ByteOut), 32'h3C);
    checkOutput("abort_sspif", 32'(SSPIF), 32'h0);
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_partial", 32'(ByteOut), 32'h3C);
    applyStimulus(1'b0, 1'b1, 1'b1);
    checkOutput("abort_full", 32'(ByteOut), 32'hFF);
    checkOutput("abort_full_flag", 32'(SSPIF), 32'h1);

    // Reset in the middle of a word.
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("midrst_byteout", 32'(ByteOut), 32'h00);
    checkOutput("midrst_dataout", 32'(Data_Out), 32'h0);
    sendByte(8'h5A, echo);
    checkOutput("midrst_word", 32'(ByteOut), 32'h5A);
    checkOutput("midrst_echo", 32'(echo), 32'h00);

    // Random traffic, mostly selected, checked only through the scoreboard.
    for (int i = 0; i < 80; i++)
      applyStimulus(1'b0, ($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)));

    checkOutput("scoreboard_empty", 32'(scoreboard.size()), 32'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
